pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Parametrised fetch-address sequencer: owns the PC/nPC pair for the pipelined core and feeds I_MEM.
//   Supports SPARC-style delayed control transfer (one delay slot, optional annul) or non-delayed mode.
//   Also supports pipeline stall, registered redirects from EX, and a highest-priority trap redirect.
//   Sits between the EX-stage target logic and the IF stage, replacing the inline PC/nPC registers.
// PARAMETERS
//   AW          32  address width in bits
//   INC         4   bytes per instruction; power of two, >=1
//   RESET_PC    0   PC value after reset; nPC resets to RESET_PC+INC
//   DELAYED     1   1 = delayed-branch mode (one delay slot); 0 = redirect takes effect immediately
// PORTS
//   clk            in   1   clock, rising edge
//   reset          in   1   asynchronous, active-high
//   stall_i        in   1   hold PC/nPC/kill this cycle (IF/ID not advancing)
//   redir_valid_i  in   1   EX-stage control transfer taken this cycle
//   redir_target_i in   AW  target address of the transfer
//   redir_annul_i  in   1   annul the delay slot (DELAYED=1 only)
//   trap_valid_i   in   1   trap/exception redirect; ignores stall_i
//   trap_vector_i  in   AW  trap handler address
//   pc_o           out  AW  current fetch address (to I_MEM)
//   npc_o          out  AW  next fetch address (carried into IF/ID)
//   fetch_kill_o   out  1   instruction fetched at pc_o is annulled; downstream treats it as a NOP
//   redir_drop_o   out  1   one-cycle pulse: a pending redirect was overwritten
//   misalign_o     out  1   one-cycle pulse: accepted target had nonzero low log2(INC) bits
// BEHAVIOUR
//   Reset (async): pc=RESET_PC, npc=RESET_PC+INC, fetch_kill=0, pending=0, redir_drop=0, misalign=0.
//   Internal pending register (pend_v, pend_tgt, pend_annul) latches a redirect that arrives while stalled.
//   Next-state priority at each rising edge, highest first:
//   1 trap_valid_i: pc<=vec, npc<=vec+INC, kill<=0, pend_v<=0.
//      Taken even when stall_i=1; any redirect in the same cycle or pending is discarded.
//   2 stall_i=1: pc/npc/kill hold.
//      If redir_valid_i: latch it into pending; if pend_v was already 1, the new redirect wins and redir_drop_o pulses.
//   3 effective redirect (redir_valid_i, else pend_v; the live input wins over pending, and pend_v is cleared):
//      DELAYED=1: pc<=npc, npc<=tgt, kill<=annul.
//        The delay slot at old npc is still fetched.
//      DELAYED=0: pc<=tgt, npc<=tgt+INC, kill<=0.
//        Annul is ignored.
//      Live redirect with pend_v=1 also pulses redir_drop_o.
//   4 otherwise: pc<=npc, npc<=npc+INC, kill<=0.
//   Latency: a redirect presented on cycle N is visible on pc_o (DELAYED=0) or npc_o (DELAYED=1) after edge N.
//   Address arithmetic: modulo 2^AW; npc+INC wraps silently (e.g. 0xFFFFFFFC -> 0).
//   Alignment: an accepted target (redirect or trap) has its low log2(INC) bits forced to 0.
//      misalign_o pulses on the cycle the nonzero-bit target is applied; the redirect is still taken.
//   fetch_kill_o: registered; describes the instruction at the current pc_o and holds while stalled.
//   redir_drop_o and misalign_o: registered single-cycle pulses, 0 in all other cycles.
//   Reset mid-operation: pending redirect and kill are lost; fetch restarts at RESET_PC.
// TESTING
//   Reset, 3 free cycles (AW=32, INC=4) -> pc 0,4,8,12; npc 4,8,12,16; kill=0.
//   DELAYED=1, pc=8/npc=12, redirect to 0x40 annul=0 -> next pc=12 npc=0x40, then pc=0x40 npc=0x44.
//   Same with annul=1 -> pc=12 with kill=1 for exactly one cycle, then pc=0x40 kill=0.
//   DELAYED=0, redirect to 0x80 -> pc=0x80 npc=0x84 the next cycle; annul=1 gives kill=0.
//   stall=1 for 3 cycles, redirect 0x100 on stall cycle 1, redirect 0x200 on stall cycle 2 -> pc/npc frozen;
//      redir_drop pulses once; after release npc=0x200.
//   Trap to 0x10 while stall=1 and redirect active -> pc=0x10 npc=0x14 next edge; pending cleared.
//   pc=0xFFFFFFF8 free-running -> npc wraps to 0; target 0x42 -> applied as 0x40 with misalign_o=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: owns the PC/nPC pair, with delayed or immediate control
// transfer, stall with a one-deep pending redirect, and a highest-priority trap redirect.
module pc_sequencer #(
  parameter int              AW       = 32,
  parameter int              INC      = 4,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter bit              DELAYED  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_i,
  input  logic          redir_valid_i,
  input  logic [AW-1:0] redir_target_i,
  input  logic          redir_annul_i,
  input  logic          trap_valid_i,
  input  logic [AW-1:0] trap_vector_i,
  output logic [AW-1:0] pc_o,
  output logic [AW-1:0] npc_o,
  output logic          fetch_kill_o,
  output logic          redir_drop_o,
  output logic          misalign_o
);

  localparam int            SH    = $clog2(INC);
  localparam logic [AW-1:0] INCV  = AW'(INC);
  localparam logic [AW-1:0] ALIGN = ~((AW'(1) << SH) - AW'(1));

  logic          pend_v;
  logic [AW-1:0] pend_tgt;
  logic          pend_annul;

  logic          eff_v;
  logic [AW-1:0] eff_raw;
  logic [AW-1:0] eff_tgt;
  logic          eff_annul;
  logic [AW-1:0] trap_tgt;

  // The live redirect always wins over a pending one.
  always_comb begin
    eff_v     = redir_valid_i | pend_v;
    eff_raw   = redir_valid_i ? redir_target_i : pend_tgt;
    eff_annul = redir_valid_i ? redir_annul_i  : pend_annul;
    eff_tgt   = eff_raw & ALIGN;
    trap_tgt  = trap_vector_i & ALIGN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_o         <= RESET_PC;
      npc_o        <= RESET_PC + INCV;
      fetch_kill_o <= 1'b0;
      redir_drop_o <= 1'b0;
      misalign_o   <= 1'b0;
      pend_v       <= 1'b0;
      pend_tgt     <= '0;
      pend_annul   <= 1'b0;
    end else begin
      redir_drop_o <= 1'b0;
      misalign_o   <= 1'b0;
      if (trap_valid_i) begin
        pc_o         <= trap_tgt;
        npc_o        <= trap_tgt + INCV;
        fetch_kill_o <= 1'b0;
        pend_v       <= 1'b0;
        misalign_o   <= |(trap_vector_i & ~ALIGN);
      end else if (stall_i) begin
        if (redir_valid_i) begin
          pend_v       <= 1'b1;
          pend_tgt     <= redir_target_i;
          pend_annul   <= redir_annul_i;
          redir_drop_o <= pend_v;
        end
      end else if (eff_v) begin
        pend_v       <= 1'b0;
        redir_drop_o <= redir_valid_i & pend_v;
        misalign_o   <= |(eff_raw & ~ALIGN);
        if (DELAYED) begin
          // Delay slot at the old npc is still fetched; annul only marks it dead.
          pc_o         <= npc_o;
          npc_o        <= eff_tgt;
          fetch_kill_o <= eff_annul;
        end else begin
          pc_o         <= eff_tgt;
          npc_o        <= eff_tgt + INCV;
          fetch_kill_o <= 1'b0;
        end
      end else begin
        pc_o         <= npc_o;
        npc_o        <= npc_o + INCV;
        fetch_kill_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: one delayed-mode and one immediate-mode instance share
// stimulus; each directed vector names which instance it checks after the next rising edge.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall, rv, ra, tv;
  logic [31:0] rt, tvec;

  logic [31:0] pc1, npc1, pc0, npc0;
  logic        k1, d1, m1, k0, d0, m0;

  typedef struct {
    int          sel;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        k;
    logic        d;
    logic        m;
    string       nm;
  } exp_t;

  exp_t q[$];
  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.AW(32), .INC(4), .RESET_PC(32'h0), .DELAYED(1'b1)) u_dly (
    .clk(clk), .reset(reset), .stall_i(stall), .redir_valid_i(rv), .redir_target_i(rt),
    .redir_annul_i(ra), .trap_valid_i(tv), .trap_vector_i(tvec),
    .pc_o(pc1), .npc_o(npc1), .fetch_kill_o(k1), .redir_drop_o(d1), .misalign_o(m1));

  pc_sequencer #(.AW(32), .INC(4), .RESET_PC(32'h0), .DELAYED(1'b0)) u_imm (
    .clk(clk), .reset(reset), .stall_i(stall), .redir_valid_i(rv), .redir_target_i(rt),
    .redir_annul_i(ra), .trap_valid_i(tv), .trap_vector_i(tvec),
    .pc_o(pc0), .npc_o(npc0), .fetch_kill_o(k0), .redir_drop_o(d0), .misalign_o(m0));

  // Monitor: every edge presents a new state; compare it against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        logic [31:0] apc, anpc;
        logic ak, ad, am;
        e = q.pop_front();
        if (e.sel == 1) begin apc = pc1; anpc = npc1; ak = k1; ad = d1; am = m1; end
        else            begin apc = pc0; anpc = npc0; ak = k0; ad = d0; am = m0; end
        applied++;
        if (apc !== e.pc || anpc !== e.npc || ak !== e.k || ad !== e.d || am !== e.m) begin
          miscompares++;
          $display("FAIL %s: got pc=%h npc=%h kill=%b drop=%b mis=%b, want pc=%h npc=%h kill=%b drop=%b mis=%b",
                   e.nm, apc, anpc, ak, ad, am, e.pc, e.npc, e.k, e.d, e.m);
        end
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic v, input logic [31:0] t,
                      input logic a, input logic tr, input logic [31:0] vec,
                      input int sel, input logic [31:0] epc, input logic [31:0] enpc,
                      input logic ek, input logic ed, input logic em, input string nm);
    exp_t e;
    @(negedge clk);
    reset = r; stall = s; rv = v; rt = t; ra = a; tv = tr; tvec = vec;
    e.sel = sel; e.pc = epc; e.npc = enpc; e.k = ek; e.d = ed; e.m = em; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    stall = 0; rv = 0; rt = '0; ra = 0; tv = 0; tvec = '0;
    //    rst st rv tgt          an tr vec          sel pc           npc          k  d  m
    step(1, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0,        32'h4,       0, 0, 0, "reset");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h4,        32'h8,       0, 0, 0, "free1");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h8,        32'hC,       0, 0, 0, "free2");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'hC,        32'h10,      0, 0, 0, "free3");
    step(1, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0,        32'h4,       0, 0, 0, "reset2");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h4,        32'h8,       0, 0, 0, "run4");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h8,        32'hC,       0, 0, 0, "run8");
    step(0, 0, 1, 32'h40,      0, 0, 32'h0,       1, 32'hC,        32'h40,      0, 0, 0, "dly_redir");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h40,       32'h44,      0, 0, 0, "dly_target");
    step(0, 0, 1, 32'h80,      1, 0, 32'h0,       1, 32'h44,       32'h80,      1, 0, 0, "annul_slot");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h80,       32'h84,      0, 0, 0, "annul_clear");
    step(0, 1, 1, 32'h100,     0, 0, 32'h0,       1, 32'h80,       32'h84,      0, 0, 0, "stall_latch");
    step(0, 1, 1, 32'h200,     0, 0, 32'h0,       1, 32'h80,       32'h84,      0, 1, 0, "stall_drop");
    step(0, 1, 0, 32'h0,       0, 0, 32'h0,       1, 32'h80,       32'h84,      0, 0, 0, "stall_hold");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h84,       32'h200,     0, 0, 0, "pend_apply");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h200,      32'h204,     0, 0, 0, "pend_target");
    step(0, 1, 1, 32'h300,     0, 1, 32'h10,      1, 32'h10,       32'h14,      0, 0, 0, "trap_stall");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h14,       32'h18,      0, 0, 0, "trap_nopend");
    step(0, 1, 1, 32'h500,     0, 0, 32'h0,       1, 32'h14,       32'h18,      0, 0, 0, "pend_for_trap");
    step(0, 0, 0, 32'h0,       0, 1, 32'h20,      1, 32'h20,       32'h24,      0, 0, 0, "trap_kills_pend");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h24,       32'h28,      0, 0, 0, "after_trap");
    step(0, 1, 1, 32'h600,     0, 0, 32'h0,       1, 32'h24,       32'h28,      0, 0, 0, "pend_600");
    step(0, 0, 1, 32'h700,     0, 0, 32'h0,       1, 32'h28,       32'h700,     0, 1, 0, "live_over_pend");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h700,      32'h704,     0, 0, 0, "live_target");
    step(0, 0, 1, 32'h42,      0, 0, 32'h0,       1, 32'h704,      32'h40,      0, 0, 1, "dly_misalign");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h40,       32'h44,      0, 0, 0, "mis_clear");
    step(0, 0, 0, 32'h0,       0, 1, 32'hFFFFFFF8, 1, 32'hFFFFFFF8, 32'hFFFFFFFC, 0, 0, 0, "trap_top");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'hFFFFFFFC, 32'h0,       0, 0, 0, "npc_wrap");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0,        32'h4,       0, 0, 0, "pc_wrap");
    step(0, 0, 0, 32'h0,       0, 1, 32'h13,      1, 32'h10,       32'h14,      0, 0, 1, "trap_misalign");
    step(0, 0, 1, 32'h90,      1, 0, 32'h0,       1, 32'h14,       32'h90,      1, 0, 0, "kill_set");
    step(0, 1, 0, 32'h0,       0, 0, 32'h0,       1, 32'h14,       32'h90,      1, 0, 0, "kill_hold");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h90,       32'h94,      0, 0, 0, "kill_release");
    step(0, 1, 1, 32'h100,     1, 0, 32'h0,       1, 32'h90,       32'h94,      0, 0, 0, "pend_pre_reset");
    step(1, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0,        32'h4,       0, 0, 0, "mid_reset");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h4,        32'h8,       0, 0, 0, "pend_lost");
    // Immediate-transfer instance.
    step(1, 0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,        32'h4,       0, 0, 0, "imm_reset");
    step(0, 0, 1, 32'h80,      1, 0, 32'h0,       0, 32'h80,       32'h84,      0, 0, 0, "imm_redir");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h84,       32'h88,      0, 0, 0, "imm_free");
    step(0, 1, 1, 32'h100,     0, 0, 32'h0,       0, 32'h84,       32'h88,      0, 0, 0, "imm_stall1");
    step(0, 1, 1, 32'h200,     0, 0, 32'h0,       0, 32'h84,       32'h88,      0, 1, 0, "imm_drop");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h200,      32'h204,     0, 0, 0, "imm_pend");
    step(0, 0, 1, 32'h42,      0, 0, 32'h0,       0, 32'h40,       32'h44,      0, 0, 1, "imm_misalign");
    step(0, 0, 0, 32'h0,       0, 1, 32'hFFFFFFF8, 0, 32'hFFFFFFF8, 32'hFFFFFFFC, 0, 0, 0, "imm_trap");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 32'hFFFFFFFC, 32'h0,       0, 0, 0, "imm_wrap");
    step(0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,        32'h4,       0, 0, 0, "imm_pcwrap");
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
